// File: rtl/hci_core_stream_writer_pkg.sv
// ---------------------------------------------------------------------------
// hci_core_stream_writer_pkg
// Shared types and constants for the stream-to-TCDM writer.
//   hci_wstream_ctrl_t  : start request plus linear transfer description
//   hci_wstream_flags_t : handshake/status flags and the beat counter
//   hci_wstream_state_t : FSM state encoding (IDLE / WORKING / DONE)
// ---------------------------------------------------------------------------
package hci_core_stream_writer_pkg;

  // Default TCDM data width; the stream side is 32 bits narrower.
  localparam int unsigned DEFAULT_DW = 64;

  // Width of the length/counter fields carried in ctrl/flags.
  localparam int unsigned HCI_WSTREAM_CNT_W = 16;

  typedef struct packed {
    logic                         req_start;
    logic [31:0]                  base_addr;
    logic [31:0]                  stride;
    logic [HCI_WSTREAM_CNT_W-1:0] tot_len;
  } hci_wstream_ctrl_t;

  typedef struct packed {
    logic                         ready_start;
    logic                         done;
    logic                         busy;
    logic [HCI_WSTREAM_CNT_W-1:0] cnt;
  } hci_wstream_flags_t;

  typedef logic [1:0] hci_wstream_state_t;

  localparam hci_wstream_state_t WS_IDLE    = 2'd0;
  localparam hci_wstream_state_t WS_WORKING = 2'd1;
  localparam hci_wstream_state_t WS_DONE    = 2'd2;

  // TCDM addresses are always word aligned; the byte offset is folded
  // into the data/byte-enable shift instead.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/hci_core_lin_addrgen.sv
// ---------------------------------------------------------------------------
// hci_core_lin_addrgen
// Linear address generator: addr = base + n*stride, modulo 2^32.
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   clear_i            : synchronous clear back to address 0
//   enable_i           : low freezes the generator
//   load_i             : capture base_i/stride_i
//   base_i, stride_i   : start address and two's-complement stride
//   step_i             : advance by one stride
//   addr_o             : current byte address
// ---------------------------------------------------------------------------
module hci_core_lin_addrgen (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        enable_i,
  input  logic        load_i,
  input  logic [31:0] base_i,
  input  logic [31:0] stride_i,
  input  logic        step_i,
  output logic [31:0] addr_o
);

  logic [31:0] addr_q;
  logic [31:0] stride_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q   <= '0;
      stride_q <= '0;
    end else if (clear_i) begin
      addr_q   <= '0;
      stride_q <= '0;
    end else if (enable_i) begin
      if (load_i) begin
        addr_q   <= base_i;
        stride_q <= stride_i;
      end else if (step_i) begin
        // Plain 32-bit add: negative strides and wrap-around come for free.
        addr_q <= addr_q + stride_q;
      end
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/hci_core_stream_writer.sv
// ---------------------------------------------------------------------------
// hci_core_stream_writer
// Consumes a data stream and writes it to TCDM along a linear address
// pattern. Misaligned destinations are handled by shifting data/strobes into
// a TCDM word that is 32 bits wider than the stream.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   test_mode_i     : test mode, no functional effect
//   clear_i         : synchronous soft clear
//   enable_i        : global enable, low freezes everything
//   tcdm_*          : HCI core master port (write only, r_* side unused)
//   stream_*        : HWPE-Stream sink (valid/ready/data/strb)
//   ctrl_i          : start request and transfer description
//   flags_o         : ready_start / done / busy / beat count
// ---------------------------------------------------------------------------
module hci_core_stream_writer
  import hci_core_stream_writer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DW,
  parameter int unsigned TRANS_CNT  = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      test_mode_i,
  input  logic                      clear_i,
  input  logic                      enable_i,
  // TCDM master
  output logic                      tcdm_req,
  input  logic                      tcdm_gnt,
  output logic [31:0]               tcdm_add,
  output logic                      tcdm_wen,
  output logic [DATA_WIDTH-1:0]     tcdm_data,
  output logic [DATA_WIDTH/8-1:0]   tcdm_be,
  output logic                      tcdm_lrdy,
  output logic [15:0]               tcdm_boffs,
  output logic [0:0]                tcdm_user,
  // stream sink
  input  logic                      stream_valid,
  output logic                      stream_ready,
  input  logic [DATA_WIDTH-33:0]    stream_data,
  input  logic [DATA_WIDTH/8-5:0]   stream_strb,
  // control / status
  input  hci_wstream_ctrl_t         ctrl_i,
  output hci_wstream_flags_t        flags_o
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  hci_wstream_state_t   state_q;
  logic [TRANS_CNT-1:0] cnt_q;
  logic [TRANS_CNT-1:0] tot_len_q;
  logic [31:0]          addr;

  logic beat_req;
  logic handshake;
  logic last_beat;
  logic load_addr;

  logic [DATA_WIDTH-1:0] data_shifted;
  logic [BE_WIDTH-1:0]   be_shifted;

  // Request follows the stream combinationally; it only exists in WORKING.
  assign beat_req  = (state_q == WS_WORKING) & enable_i & stream_valid;
  assign handshake = beat_req & tcdm_gnt;
  assign last_beat = (cnt_q == tot_len_q - TRANS_CNT'(1));
  assign load_addr = (state_q == WS_IDLE) & ctrl_i.req_start;

  hci_core_lin_addrgen i_addrgen (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (clear_i),
    .enable_i (enable_i),
    .load_i   (load_addr),
    .base_i   (ctrl_i.base_addr),
    .stride_i (ctrl_i.stride),
    .step_i   (handshake),
    .addr_o   (addr)
  );

  // Byte offset within the word shifts both payload and strobes; the extra
  // 32 bits of TCDM width absorb the overflow.
  assign data_shifted = {32'b0, stream_data} << {addr[1:0], 3'b000};
  assign be_shifted   = {4'b0, stream_strb} << addr[1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= WS_IDLE;
      cnt_q     <= '0;
      tot_len_q <= '0;
    end else if (clear_i) begin
      state_q   <= WS_IDLE;
      cnt_q     <= '0;
      tot_len_q <= '0;
    end else if (enable_i) begin
      case (state_q)
        WS_IDLE: begin
          if (ctrl_i.req_start) begin
            tot_len_q <= ctrl_i.tot_len[TRANS_CNT-1:0];
            cnt_q     <= '0;
            state_q   <= (ctrl_i.tot_len[TRANS_CNT-1:0] == '0) ? WS_DONE : WS_WORKING;
          end
        end
        WS_WORKING: begin
          if (handshake) begin
            cnt_q <= cnt_q + TRANS_CNT'(1);
            if (last_beat) state_q <= WS_DONE;
          end
        end
        WS_DONE:  state_q <= WS_IDLE;
        default:  state_q <= WS_IDLE;
      endcase
    end
  end

  always_comb begin
    tcdm_req     = 1'b0;
    stream_ready = 1'b0;
    tcdm_add     = '0;
    tcdm_data    = '0;
    tcdm_be      = '0;
    if (state_q == WS_WORKING) begin
      tcdm_req     = beat_req;
      stream_ready = handshake;
      tcdm_add     = word_align(addr);
      tcdm_data    = data_shifted;
      tcdm_be      = be_shifted;
    end
  end

  assign tcdm_wen   = 1'b0;
  // Constant 1; test_mode_i is folded in only so the port has a reader.
  assign tcdm_lrdy  = 1'b1 | test_mode_i;
  assign tcdm_boffs = '0;
  assign tcdm_user  = '0;

  assign flags_o.ready_start = (state_q == WS_IDLE);
  assign flags_o.done        = (state_q == WS_DONE);
  assign flags_o.busy        = (state_q == WS_WORKING);
  assign flags_o.cnt         = HCI_WSTREAM_CNT_W'(cnt_q);

endmodule

// File: tb/tb_hci_core_stream_writer.sv
module tb_hci_core_stream_writer;
  import hci_core_stream_writer_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        test_mode_i;
  logic        clear_i;
  logic        enable_i;
  logic        tcdm_req;
  logic        tcdm_gnt;
  logic [31:0] tcdm_add;
  logic        tcdm_wen;
  logic [63:0] tcdm_data;
  logic [7:0]  tcdm_be;
  logic        tcdm_lrdy;
  logic [15:0] tcdm_boffs;
  logic [0:0]  tcdm_user;
  logic        stream_valid;
  logic        stream_ready;
  logic [31:0] stream_data;
  logic [3:0]  stream_strb;
  hci_wstream_ctrl_t  ctrl_i;
  hci_wstream_flags_t flags_o;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk_i = ~clk_i;

  hci_core_stream_writer #(.DATA_WIDTH(64), .TRANS_CNT(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .test_mode_i(test_mode_i),
    .clear_i(clear_i), .enable_i(enable_i),
    .tcdm_req(tcdm_req), .tcdm_gnt(tcdm_gnt), .tcdm_add(tcdm_add),
    .tcdm_wen(tcdm_wen), .tcdm_data(tcdm_data), .tcdm_be(tcdm_be),
    .tcdm_lrdy(tcdm_lrdy), .tcdm_boffs(tcdm_boffs), .tcdm_user(tcdm_user),
    .stream_valid(stream_valid), .stream_ready(stream_ready),
    .stream_data(stream_data), .stream_strb(stream_strb),
    .ctrl_i(ctrl_i), .flags_o(flags_o)
  );

  // One line per TCDM write transaction.
  always @(posedge clk_i) begin
    if (rst_ni && tcdm_req && tcdm_gnt)
      $display("write add=0x%08h data=0x%016h be=0x%02h cnt=%0d",
               tcdm_add, tcdm_data, tcdm_be, flags_o.cnt);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        start;
    logic [31:0] base;
    logic [31:0] stride;
    logic [15:0] len;
    logic        valid;
    logic        gnt;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        e_req;
    logic        e_rdy;
    logic [31:0] e_add;
    logic [63:0] e_data;
    logic [7:0]  e_be;
    logic [15:0] e_cnt;
    logic        e_busy;
    logic        e_done;
    logic        e_rs;
  } vec_t;

  vec_t vq[$];

  task automatic drive(input logic start, input logic [31:0] base, input logic [31:0] stride,
                       input logic [15:0] len, input logic valid, input logic gnt,
                       input logic [31:0] data, input logic [3:0] strb);
    ctrl_i.req_start = start;
    ctrl_i.base_addr = base;
    ctrl_i.stride    = stride;
    ctrl_i.tot_len   = len;
    stream_valid     = valid;
    tcdm_gnt         = gnt;
    stream_data      = data;
    stream_strb      = strb;
  endtask

  initial begin
    // Test 1: aligned linear transfer with a valid bubble.
    //        start base    stride len  v  g  data          strb  req rdy add           e_data                  be     cnt  bsy dn rs
    vq.push_back('{1, 32'h1000, 4, 4, 1, 1, 32'h0, 4'hF,       0, 0, 32'h0,    64'h0,                  8'h00, 0, 0, 0, 1});
    vq.push_back('{0, 32'h0, 0, 0,    1, 1, 32'h01020304, 4'hF, 1, 1, 32'h1000, 64'h0000_0000_0102_0304, 8'h0F, 0, 1, 0, 0});
    vq.push_back('{0, 32'h0, 0, 0,    1, 1, 32'h05060708, 4'hF, 1, 1, 32'h1004, 64'h0000_0000_0506_0708, 8'h0F, 1, 1, 0, 0});
    vq.push_back('{0, 32'h0, 0, 0,    0, 1, 32'h090A0B0C, 4'hF, 0, 0, 32'h1008, 64'h0000_0000_090A_0B0C, 8'h0F, 2, 1, 0, 0});
    vq.push_back('{0, 32'h0, 0, 0,    1, 1, 32'h090A0B0C, 4'hF, 1, 1, 32'h1008, 64'h0000_0000_090A_0B0C, 8'h0F, 2, 1, 0, 0});
    vq.push_back('{0, 32'h0, 0, 0,    1, 1, 32'h0D0E0F10, 4'hF, 1, 1, 32'h100C, 64'h0000_0000_0D0E_0F10, 8'h0F, 3, 1, 0, 0});
    vq.push_back('{0, 32'h0, 0, 0,    1, 1, 32'h0D0E0F10, 4'hF, 0, 0, 32'h0,    64'h0,                  8'h00, 4, 0, 1, 0});
    vq.push_back('{0, 32'h0, 0, 0,    1, 1, 32'h0D0E0F10, 4'hF, 0, 0, 32'h0,    64'h0,                  8'h00, 4, 0, 0, 1});
    // Tests 2/3: misaligned base 0x1002 stride 7 (offsets 2,1,0), grant stall on beat 2.
    vq.push_back('{1, 32'h1002, 7, 3, 1, 1, 32'hAABBCCDD, 4'hF, 0, 0, 32'h0,    64'h0,                  8'h00, 4, 0, 0, 1});
    vq.push_back('{0, 32'h0, 0, 0,    1, 1, 32'hAABBCCDD, 4'hF, 1, 1, 32'h1000, 64'h0000_AABB_CCDD_0000, 8'h3C, 0, 1, 0, 0});
    vq.push_back('{0, 32'h0, 0, 0,    1, 0, 32'h11223344, 4'h3, 1, 0, 32'h1008, 64'h0000_0011_2233_4400, 8'h06, 1, 1, 0, 0});
    vq.push_back('{0, 32'h0, 0, 0,    1, 0, 32'h11223344, 4'h3, 1, 0, 32'h1008, 64'h0000_0011_2233_4400, 8'h06, 1, 1, 0, 0});
    vq.push_back('{0, 32'h0, 0, 0,    1, 0, 32'h11223344, 4'h3, 1, 0, 32'h1008, 64'h0000_0011_2233_4400, 8'h06, 1, 1, 0, 0});
    vq.push_back('{0, 32'h0, 0, 0,    1, 1, 32'h11223344, 4'h3, 1, 1, 32'h1008, 64'h0000_0011_2233_4400, 8'h06, 1, 1, 0, 0});
    vq.push_back('{0, 32'h0, 0, 0,    1, 1, 32'h55667788, 4'h8, 1, 1, 32'h1010, 64'h0000_0000_5566_7788, 8'h08, 2, 1, 0, 0});
    vq.push_back('{0, 32'h0, 0, 0,    0, 0, 32'h0, 4'h0,       0, 0, 32'h0,    64'h0,                  8'h00, 3, 0, 1, 0});
    vq.push_back('{0, 32'h0, 0, 0,    0, 0, 32'h0, 4'h0,       0, 0, 32'h0,    64'h0,                  8'h00, 3, 0, 0, 1});

    rst_ni = 1'b0; test_mode_i = 1'b0; clear_i = 1'b0; enable_i = 1'b1;
    drive(0, 0, 0, 0, 1, 1, 32'hFFFF_FFFF, 4'hF);
    #12;
    chk("reset_req", tcdm_req, 0);
    chk("reset_ready", stream_ready, 0);
    chk("reset_ready_start", flags_o.ready_start, 1);
    chk("reset_busy", flags_o.busy, 0);
    chk("reset_done", flags_o.done, 0);
    chk("reset_cnt", flags_o.cnt, 0);
    chk("reset_add", tcdm_add, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i].start, vq[i].base, vq[i].stride, vq[i].len, vq[i].valid, vq[i].gnt,
            vq[i].data, vq[i].strb);
      #1;
      chk($sformatf("v%0d_req", i),  tcdm_req,            vq[i].e_req);
      chk($sformatf("v%0d_rdy", i),  stream_ready,        vq[i].e_rdy);
      chk($sformatf("v%0d_add", i),  tcdm_add,            vq[i].e_add);
      chk($sformatf("v%0d_data", i), tcdm_data,           vq[i].e_data);
      chk($sformatf("v%0d_be", i),   tcdm_be,             vq[i].e_be);
      chk($sformatf("v%0d_cnt", i),  flags_o.cnt,         vq[i].e_cnt);
      chk($sformatf("v%0d_busy", i), flags_o.busy,        vq[i].e_busy);
      chk($sformatf("v%0d_done", i), flags_o.done,        vq[i].e_done);
      chk($sformatf("v%0d_rs", i),   flags_o.ready_start, vq[i].e_rs);
      chk($sformatf("v%0d_wen", i),  tcdm_wen,            0);
      @(negedge clk_i);
    end

    // Test 4: clear after two beats of an 8-beat transfer.
    drive(1, 32'h2000, 4, 8, 1, 1, 32'h12345678, 4'hF); #1;
    chk("clr_start_rs", flags_o.ready_start, 1);
    @(negedge clk_i);
    drive(0, 0, 0, 0, 1, 1, 32'h12345678, 4'hF); #1;
    chk("clr_b0_add", tcdm_add, 32'h2000);
    @(negedge clk_i); #1;
    chk("clr_b1_add", tcdm_add, 32'h2004);
    @(negedge clk_i);
    clear_i = 1'b1; tcdm_gnt = 1'b0; #1;
    chk("clr_pre_cnt", flags_o.cnt, 2);
    @(negedge clk_i);
    clear_i = 1'b0; tcdm_gnt = 1'b1; #1;
    chk("clr_idle_req", tcdm_req, 0);
    chk("clr_idle_cnt", flags_o.cnt, 0);
    chk("clr_idle_rs", flags_o.ready_start, 1);
    chk("clr_idle_busy", flags_o.busy, 0);
    chk("clr_idle_done", flags_o.done, 0);
    @(negedge clk_i);
    drive(1, 32'h3000, 4, 1, 1, 1, 32'h0BADBEEF, 4'hF); #1;
    chk("clr_idle2_done", flags_o.done, 0);
    @(negedge clk_i);
    drive(0, 0, 0, 0, 1, 1, 32'h0BADBEEF, 4'hF); #1;
    chk("clr_new_add", tcdm_add, 32'h3000);
    chk("clr_new_req", tcdm_req, 1);
    @(negedge clk_i); #1;
    chk("clr_new_done", flags_o.done, 1);
    chk("clr_new_cnt", flags_o.cnt, 1);
    @(negedge clk_i);

    // Test 5: zero length.
    drive(1, 32'h5000, 4, 0, 1, 1, 32'h1, 4'hF); #1;
    chk("zl_start_req", tcdm_req, 0);
    @(negedge clk_i);
    drive(0, 0, 0, 0, 1, 1, 32'h1, 4'hF); #1;
    chk("zl_done", flags_o.done, 1);
    chk("zl_done_req", tcdm_req, 0);
    chk("zl_done_busy", flags_o.busy, 0);
    chk("zl_done_cnt", flags_o.cnt, 0);
    @(negedge clk_i); #1;
    chk("zl_idle_done", flags_o.done, 0);
    chk("zl_idle_req", tcdm_req, 0);
    chk("zl_idle_rs", flags_o.ready_start, 1);
    @(negedge clk_i);

    // Test 6a: enable freeze mid-transfer.
    drive(1, 32'h4000, 32'h10, 3, 1, 1, 32'hCAFEF00D, 4'hF); #1;
    @(negedge clk_i);
    drive(0, 0, 0, 0, 1, 1, 32'hCAFEF00D, 4'hF); #1;
    chk("en_b0_add", tcdm_add, 32'h4000);
    @(negedge clk_i);
    enable_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("en_frz%0d_req", k), tcdm_req, 0);
      chk($sformatf("en_frz%0d_rdy", k), stream_ready, 0);
      chk($sformatf("en_frz%0d_cnt", k), flags_o.cnt, 1);
      chk($sformatf("en_frz%0d_busy", k), flags_o.busy, 1);
      @(negedge clk_i);
    end
    enable_i = 1'b1; #1;
    chk("en_res_req", tcdm_req, 1);
    chk("en_res_add", tcdm_add, 32'h4010);
    chk("en_res_cnt", flags_o.cnt, 1);
    @(negedge clk_i); #1;
    chk("en_b2_add", tcdm_add, 32'h4020);
    @(negedge clk_i); #1;
    chk("en_done", flags_o.done, 1);
    chk("en_done_cnt", flags_o.cnt, 3);
    @(negedge clk_i);

    // Test 6b: address wrap past 2^32.
    drive(1, 32'hFFFF_FFFC, 4, 2, 1, 1, 32'h00C0FFEE, 4'hF); #1;
    @(negedge clk_i);
    drive(0, 0, 0, 0, 1, 1, 32'h00C0FFEE, 4'hF); #1;
    chk("wrap_b0_add", tcdm_add, 32'hFFFF_FFFC);
    @(negedge clk_i); #1;
    chk("wrap_b1_add", tcdm_add, 32'h0000_0000);
    chk("wrap_b1_cnt", flags_o.cnt, 1);
    @(negedge clk_i); #1;
    chk("wrap_done", flags_o.done, 1);
    @(negedge clk_i); #1;
    chk("wrap_idle_rs", flags_o.ready_start, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Hard bound on simulated time so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
